// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash responder: FSM state encoding and the
// command/field-length constants of the read protocol.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COMMAND,
    ADDRESS,
    DUMMY,
    DATA,
    IGNORE
  } spi_state_e;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam int         ADDRESS_LENGTH = 24;
  localparam int         DUMMY_LENGTH   = 8;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchronizer for one asynchronous SPI input, with rise/fall pulses
// derived from the last two synchronized samples.
module spi_input_sync #(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RESET_VALUE}};
      prev  <= RESET_VALUE;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      prev <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = chain[STAGES-1] & ~prev;
  assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 read-only flash responder backed by a preloadable byte memory.
// Define FLASH_FAST_READ_EN to also accept command 0x0B (fast read with 8 dummy clocks).
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int ADDRESS_BITS = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    csb,
  input  logic                    sclk,
  input  logic                    mosi,
  output logic                    miso,
  output logic                    misoEnable,
  input  logic                    loadEnable,
  input  logic [ADDRESS_BITS-1:0] loadAddress,
  input  logic [7:0]              loadData,
  output logic                    busy
);

  localparam logic [4:0] ADDR_LAST = 5'(ADDRESS_LENGTH - 1);
  localparam logic [4:0] ADDR_DONE = 5'(ADDRESS_LENGTH);
  localparam logic [4:0] CMD_LAST  = 5'd7;
  localparam logic [4:0] BYTE_DONE = 5'd8;
  localparam logic [ADDRESS_BITS-1:0] ADDR_ONE = ADDRESS_BITS'(1);
`ifdef FLASH_FAST_READ_EN
  localparam logic [4:0] DUMMY_DONE = 5'(DUMMY_LENGTH);
`endif

  logic csb_s, csb_rise, csb_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_csb (
    .clk(clk), .rst(rst), .d(csb), .q(csb_s), .rise(csb_rise), .fall(csb_fall)
  );
  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi), .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{csb_rise, csb_fall, sclk_s, mosi_rise, mosi_fall};

  // Preload memory; intentionally untouched by reset.
  logic [7:0] mem [0:(2**ADDRESS_BITS)-1];

  always_ff @(posedge clk) begin
    if (loadEnable) begin
      mem[loadAddress] <= loadData;
    end
  end

  // The csb synchronizer is preset high, so its output only reflects the pin
  // once the chain has been refilled; until then a high csb must not arm us.
  logic [SYNC_STAGES-1:0] settle;
  logic                   armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      settle[0] <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        settle[i] <= settle[i-1];
      end
      if (settle[SYNC_STAGES-1] && csb_s) begin
        armed <= 1'b1;
      end
    end
  end

  spi_state_e              state, state_n;
  logic [4:0]              bit_cnt, bit_cnt_n;
  logic [23:0]             shift, shift_n;
  logic [23:0]             shifted;
  logic [ADDRESS_BITS-1:0] addr, addr_n;
  logic [ADDRESS_BITS-1:0] fetch_addr;
  logic [7:0]              data_byte, data_byte_n;
  logic [7:0]              fetch_byte;
  logic                    miso_r, miso_n;
  logic                    en_r, en_n;
`ifdef FLASH_FAST_READ_EN
  logic                    fast, fast_n;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      addr      <= '0;
      data_byte <= '0;
      miso_r    <= 1'b0;
      en_r      <= 1'b0;
`ifdef FLASH_FAST_READ_EN
      fast      <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      addr      <= addr_n;
      data_byte <= data_byte_n;
      miso_r    <= miso_n;
      en_r      <= en_n;
`ifdef FLASH_FAST_READ_EN
      fast      <= fast_n;
`endif
    end
  end

  // In DATA the next fetch is always the following byte; elsewhere it is the start address.
  assign fetch_addr = (state == DATA) ? addr + ADDR_ONE : addr;
  assign fetch_byte = mem[fetch_addr];
  assign shifted    = {shift[22:0], mosi_s};

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    addr_n      = addr;
    data_byte_n = data_byte;
    miso_n      = miso_r;
    en_n        = en_r;
`ifdef FLASH_FAST_READ_EN
    fast_n      = fast;
`endif
    if (csb_s) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      shift_n   = '0;
      miso_n    = 1'b0;
      en_n      = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (armed) begin
            state_n   = COMMAND;
            bit_cnt_n = '0;
            shift_n   = '0;
          end
        end
        COMMAND: begin
          if (sclk_rise) begin
            shift_n   = shifted;
            bit_cnt_n = bit_cnt + 5'd1;
            if (bit_cnt == CMD_LAST) begin
              bit_cnt_n = '0;
              state_n   = IGNORE;
              if (shifted[7:0] == CMD_READ) begin
                state_n = ADDRESS;
              end
`ifdef FLASH_FAST_READ_EN
              fast_n = 1'b0;
              if (shifted[7:0] == CMD_FAST_READ) begin
                state_n = ADDRESS;
                fast_n  = 1'b1;
              end
`endif
            end
          end
        end
        ADDRESS: begin
          if (sclk_rise && bit_cnt != ADDR_DONE) begin
            shift_n   = shifted;
            bit_cnt_n = bit_cnt + 5'd1;
            if (bit_cnt == ADDR_LAST) begin
              addr_n = shifted[ADDRESS_BITS-1:0];
`ifdef FLASH_FAST_READ_EN
              if (fast) begin
                state_n   = DUMMY;
                bit_cnt_n = '0;
              end
`endif
            end
          end else if (sclk_fall && bit_cnt == ADDR_DONE) begin
            data_byte_n = fetch_byte;
            miso_n      = fetch_byte[7];
            en_n        = 1'b1;
            bit_cnt_n   = 5'd1;
            state_n     = DATA;
          end
        end
`ifdef FLASH_FAST_READ_EN
        DUMMY: begin
          if (sclk_rise && bit_cnt != DUMMY_DONE) begin
            bit_cnt_n = bit_cnt + 5'd1;
          end else if (sclk_fall && bit_cnt == DUMMY_DONE) begin
            data_byte_n = fetch_byte;
            miso_n      = fetch_byte[7];
            en_n        = 1'b1;
            bit_cnt_n   = 5'd1;
            state_n     = DATA;
          end
        end
`endif
        DATA: begin
          if (sclk_fall) begin
            if (bit_cnt == BYTE_DONE) begin
              addr_n      = fetch_addr;
              data_byte_n = fetch_byte;
              miso_n      = fetch_byte[7];
              bit_cnt_n   = 5'd1;
            end else begin
              miso_n    = data_byte[~bit_cnt[2:0]];
              bit_cnt_n = bit_cnt + 5'd1;
            end
          end
        end
        IGNORE: begin
          miso_n = 1'b0;
          en_n   = 1'b0;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  assign miso       = miso_r;
  assign misoEnable = en_r;
  assign busy       = ~csb_s;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: a protocol-level model of the flash read
// predicts every sampled miso bit; literal byte expectations pin the model.
module tb_spi_flash_responder;

  localparam int HALF = 6;
`ifdef FLASH_FAST_READ_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        csb = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        miso;
  logic        misoEnable;
  logic        loadEnable = 1'b0;
  logic [15:0] loadAddress = '0;
  logic [7:0]  loadData = '0;
  logic        busy;

  spi_flash_responder #(.ADDRESS_BITS(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .csb(csb), .sclk(sclk), .mosi(mosi),
    .miso(miso), .misoEnable(misoEnable),
    .loadEnable(loadEnable), .loadAddress(loadAddress), .loadData(loadData),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Bench-side state written by the stimulus process only.
  logic [7:0] model_mem [0:65535];
  logic [7:0] lit_exp [0:31];
  int         lit_wr = 0;
  logic       expect_quiet = 1'b0;
  logic       final_req = 1'b0;

  // Scoreboard state written by the compare process only.
  int          checks = 0;
  int          errors = 0;
  int          lit_rd = 0;
  logic        final_done = 1'b0;
  logic [7:0]  exp_q[$];
  logic        csb_q = 1'b1;
  logic        sclk_q = 1'b0;
  logic        armed_m = 1'b0;
  logic        live = 1'b0;
  int unsigned rise_cnt = 0;
  int unsigned data_start = 0;
  int unsigned d = 0;
  logic [31:0] hdr = '0;
  logic [15:0] addr_m = '0;
  logic [7:0]  got = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Model: a read returns mem[(start + n) mod 2^16] MSB-first, beginning 32 rising
  // edges after csb falls (40 for fast read); every other sampled bit is silent.
  always @(negedge clk) begin
    if (rst) begin
      armed_m    = 1'b0;
      live       = 1'b0;
      data_start = 0;
      exp_q.delete();
    end else begin
      if (csb_q && !csb) begin
        live       = armed_m;
        rise_cnt   = 0;
        hdr        = '0;
        data_start = 0;
        exp_q.delete();
      end
      if (csb) armed_m = 1'b1;
      if (!csb && sclk && !sclk_q) begin
        if (live && data_start != 0 && rise_cnt >= data_start) begin
          d = rise_cnt - data_start;
          if (d % 8 == 0) exp_q.push_back(model_mem[16'(addr_m + 16'(d / 8))]);
          check("data_bit", {30'd0, misoEnable, miso}, {30'd0, 1'b1, exp_q[0][7 - (d % 8)]});
          got = {got[6:0], miso};
          if (d % 8 == 7) begin
            check("data_byte", {24'd0, got}, {24'd0, exp_q.pop_front()});
            if (lit_rd < lit_wr) begin
              check("literal_byte", {24'd0, got}, {24'd0, lit_exp[lit_rd]});
              lit_rd++;
            end
          end
        end else begin
          check("silent_bit", {30'd0, misoEnable, miso}, 32'd0);
        end
        if (rise_cnt < 32) hdr = {hdr[30:0], mosi};
        if (rise_cnt == 7) begin
          if (hdr[7:0] == 8'h03) data_start = 32;
          else if (FAST_EN && hdr[7:0] == 8'h0B) data_start = 40;
          else data_start = 0;
        end
        if (rise_cnt == 31) addr_m = hdr[15:0];
        rise_cnt++;
      end
    end
    if (expect_quiet) check("quiet_outputs", {29'd0, busy, misoEnable, miso}, 32'd0);
    if (final_req && !final_done) begin
      check("literals_consumed", lit_rd, lit_wr);
      final_done = 1'b1;
    end
    csb_q  = csb;
    sclk_q = sclk;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] b);
    loadEnable  = 1'b1;
    loadAddress = a;
    loadData    = b;
    model_mem[a] = b;
    tick(1);
    loadEnable = 1'b0;
  endtask

  task automatic push_lit(input logic [7:0] b);
    lit_exp[lit_wr] = b;
    lit_wr++;
  endtask

  task automatic spi_begin();
    expect_quiet = 1'b0;
    tick(2);
    csb = 1'b0;
    tick(HALF);
  endtask

  task automatic spi_end();
    tick(HALF);
    csb  = 1'b1;
    mosi = 1'b0;
    tick(HALF);
    expect_quiet = 1'b1;
  endtask

  task automatic spi_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      tick(HALF);
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic read_txn(input logic [7:0] cmd, input logic [23:0] a, input int data_bits);
    spi_begin();
    spi_bits(32'(cmd), 8);
    spi_bits(32'(a), 24);
    spi_bits(32'h0, data_bits);
    spi_end();
  endtask

  initial begin
    #1 rst = 1'b1;
    tick(2);
    expect_quiet = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(8);

    // Basic read of four preloaded bytes.
    preload(16'h0000, 8'hA5);
    preload(16'h0001, 8'h3C);
    preload(16'h0002, 8'h00);
    preload(16'h0003, 8'hFF);
    push_lit(8'hA5); push_lit(8'h3C); push_lit(8'h00); push_lit(8'hFF);
    read_txn(8'h03, 24'h000000, 32);

    // Address wrap from 0xFFFF to 0x0000.
    preload(16'hFFFF, 8'h11);
    preload(16'h0000, 8'h22);
    push_lit(8'h11); push_lit(8'h22);
    read_txn(8'h03, 24'h00FFFF, 16);
    preload(16'h0000, 8'hA5);

    // Upper address bits beyond ADDRESS_BITS are discarded.
    push_lit(8'hFF);
    read_txn(8'h03, 24'hAB0003, 8);

    // Unsupported command stays silent; the following read is normal.
    read_txn(8'h9F, 24'h000000, 16);
    push_lit(8'h3C);
    read_txn(8'h03, 24'h000001, 8);

    // Abort after 12 address bits, then a fresh read.
    spi_begin();
    spi_bits(32'h03, 8);
    spi_bits(32'hFFF, 12);
    spi_end();
    push_lit(8'h00); push_lit(8'hFF);
    read_txn(8'h03, 24'h000002, 16);

    // Fast read: data when enabled, silence otherwise.
    if (FAST_EN) begin
      push_lit(8'h3C); push_lit(8'h00);
    end
    read_txn(8'h0B, 24'h000001, 8 + 16);

    // Reset during DATA with csb held low: no data until csb toggles.
    push_lit(8'hA5);
    spi_begin();
    spi_bits(32'h03, 8);
    spi_bits(32'h0, 24);
    spi_bits(32'h0, 12);
    rst = 1'b1;
    expect_quiet = 1'b1;
    tick(3);
    expect_quiet = 1'b0;
    rst = 1'b0;
    tick(HALF);
    spi_bits(32'h0, 16);
    spi_end();
    push_lit(8'h3C);
    read_txn(8'h03, 24'h000001, 8);

    final_req = 1'b1;
    tick(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 SHALL have parameter ADDRESS_BITS, default 16, meaning the width of the byte address into internal memory (memory depth 2^ADDRESS_BITS bytes).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the flop count of the input synchronizers for csb, sclk and mosi.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state is on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset: asynchronous, active-high.
REQ-005 SHALL have port csb, input, 1, the SPI chip select, active low.
REQ-006 SHALL have port sclk, input, 1, the SPI clock, mode 0.
REQ-007 SHALL have port mosi, input, 1, the SPI data in (flash io0).
REQ-008 SHALL have port miso, output, 1, the SPI data out (flash io1).
REQ-009 SHALL have port misoEnable, output, 1, high while miso is actively driven.
REQ-010 SHALL have port loadEnable, input, 1, the memory preload write strobe.
REQ-011 SHALL have port loadAddress, input, ADDRESS_BITS, the preload byte address.
REQ-012 SHALL have port loadData, input, 8, the preload byte.
REQ-013 SHALL have port busy, output, 1, high whenever the synchronized csb is low.

Function
REQ-014 SHALL synchronize csb, sclk and mosi through SYNC_STAGES flops and detect sclk rising/falling edges from the last two synchronized samples.
REQ-015 SHALL require the sclk half-period to be at least 4 clk cycles; behaviour at faster sclk is undefined.
REQ-016 SHALL implement states IDLE, COMMAND, ADDRESS, DUMMY, DATA, IGNORE.
REQ-017 SHALL, on synchronized csb low, move IDLE->COMMAND and clear the bit counter.
REQ-018 SHALL shift mosi MSB-first on each sclk rising edge; after 8 bits in COMMAND, go to ADDRESS on 0x03, or IGNORE on any other value.
REQ-019 SHALL, in ADDRESS, shift 24 bits MSB-first and use the low ADDRESS_BITS as the start address; upper bits are discarded.
REQ-020 SHALL, on the sclk falling edge after the last address bit, load the addressed byte and drive its MSB on miso, asserting misoEnable.
REQ-021 SHALL, in DATA, shift out the next bit on each sclk falling edge; after 8 bits, fetch address+1 modulo 2^ADDRESS_BITS with no gap (wrap from max to 0).
REQ-022 SHALL, in IGNORE, hold miso at 0 and misoEnable low until csb rises.
REQ-023 SHALL, on synchronized csb high in any state, return to IDLE within 1 clk, deassert misoEnable, drive miso 0, and discard any partial command, address or byte.
REQ-024 SHALL, when loadEnable is high, write loadData to loadAddress on that clk edge; loads are permitted while busy, and a load to the byte currently being read takes effect on the next fetch.

Reset
REQ-025 SHALL reset to IDLE with miso=0, misoEnable=0, busy=0, counters and shift registers 0, and synchronizers preset to csb=1, sclk=0, mosi=0.
REQ-026 SHALL leave memory contents unchanged by reset.
REQ-027 SHALL, on reset asserted mid-transaction, abort immediately; after release, a still-low csb SHALL NOT start a transaction until csb has been seen high.

Configuration
REQ-028 SHALL, when FLASH_FAST_READ_EN is defined, also accept command 0x0B: ADDRESS, then DUMMY for exactly 8 sclk rising edges, then DATA as for 0x03.
REQ-029 SHALL, when FLASH_FAST_READ_EN is undefined, treat 0x0B as unsupported (IGNORE) and omit the DUMMY state logic.

Structure
REQ-030 SHALL place the state enumeration and command constants (CMD_READ=0x03, CMD_FAST_READ=0x0B, ADDRESS_LENGTH=24, DUMMY_LENGTH=8) in a shared package spi_flash_pkg.
REQ-031 SHALL implement the synchronizer and edge detector as one sub-module, spi_input_sync, instantiated once per input.

Verification
REQ-032 SHALL cover: preload 0x00..0x03 = A5 3C 00 FF; send 0x03, address 0x000000, 32 clocks -> miso bytes A5 3C 00 FF.
REQ-033 SHALL cover: preload 0xFFFF=11, 0x0000=22 (ADDRESS_BITS=16); read from 0x00FFFF for 16 clocks -> 11 then 22.
REQ-034 SHALL cover: command 0x9F -> misoEnable stays 0 and miso stays 0 until csb high; the next 0x03 read works normally.
REQ-035 SHALL cover: csb raised after 12 address bits, then a new read at 0x000002 -> returns byte at 0x02, no residue from the aborted transfer.
REQ-036 SHALL cover: with FLASH_FAST_READ_EN, 0x0B at 0x000001 plus 8 dummy clocks -> 3C 00; without it -> IGNORE behaviour.
REQ-037 SHALL cover: rst pulsed during DATA with csb held low -> outputs return to reset values, and no data is driven until csb toggles high and low again.
